// File: rtl/sync_pkg.sv
// Shared types and helpers for the synchroniser-side conditioning blocks.
// Holds the debounce FSM state encoding and the qualify-counter width helper.
package sync_pkg;

  typedef enum logic [1:0] {
    S_LOW      = 2'd0,
    S_CHK_HIGH = 2'd1,
    S_HIGH     = 2'd2,
    S_CHK_LOW  = 2'd3
  } dbnc_state_t;

  // Wide enough to hold STABLE_CYCLES itself.
  function automatic int qcnt_width(input int stable_cycles);
    return $clog2(stable_cycles + 1);
  endfunction

endpackage

// File: rtl/sync_debounce_edge_sat_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
// Meant to be reused by other status blocks along the CDC path.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/sync_debounce_edge.sv
// Debounces a level already synchronised into clk_dst: a change is accepted only
// after STABLE_CYCLES identical samples, producing a clean level plus edge pulses.
module sync_debounce_edge
  import sync_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int GLITCH_CNT_W  = 8
) (
  input  logic                    clk_dst,
  input  logic                    rst,
  input  logic                    signal_sync,
  input  logic                    glitch_clr,
  output logic                    level_out,
  output logic                    rise_pulse,
  output logic                    fall_pulse,
  output logic                    busy,
  output logic [GLITCH_CNT_W-1:0] glitch_count
);

  localparam int QW = qcnt_width(STABLE_CYCLES);
  localparam logic [QW-1:0] QTARGET = QW'(STABLE_CYCLES);

  dbnc_state_t   state_q, state_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [QW-1:0] qcnt_inc;
  logic          level_d, rise_d, fall_d;
  logic          glitch_inc;

  assign qcnt_inc = qcnt_q + QW'(1);

  always_ff @(posedge clk_dst) begin
    if (rst) begin
      state_q <= S_LOW;
      qcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      qcnt_q  <= qcnt_d;
    end
  end

  // With STABLE_CYCLES=1 the first differing sample is accepted immediately.
  always_comb begin
    state_d = state_q;
    qcnt_d  = qcnt_q;
    case (state_q)
      S_LOW: begin
        if (signal_sync) begin
          if (STABLE_CYCLES == 1) begin
            state_d = S_HIGH;
            qcnt_d  = '0;
          end else begin
            state_d = S_CHK_HIGH;
            qcnt_d  = QW'(1);
          end
        end
      end
      S_CHK_HIGH: begin
        if (!signal_sync) begin
          state_d = S_LOW;
          qcnt_d  = '0;
        end else if (qcnt_inc == QTARGET) begin
          state_d = S_HIGH;
          qcnt_d  = '0;
        end else begin
          qcnt_d = qcnt_inc;
        end
      end
      S_HIGH: begin
        if (!signal_sync) begin
          if (STABLE_CYCLES == 1) begin
            state_d = S_LOW;
            qcnt_d  = '0;
          end else begin
            state_d = S_CHK_LOW;
            qcnt_d  = QW'(1);
          end
        end
      end
      S_CHK_LOW: begin
        if (signal_sync) begin
          state_d = S_HIGH;
          qcnt_d  = '0;
        end else if (qcnt_inc == QTARGET) begin
          state_d = S_LOW;
          qcnt_d  = '0;
        end else begin
          qcnt_d = qcnt_inc;
        end
      end
      default: begin
        state_d = S_LOW;
        qcnt_d  = '0;
      end
    endcase
  end

  // Acceptances and rejections are read off the state transition itself.
  always_comb begin
    level_d    = level_out;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    glitch_inc = 1'b0;
    if ((state_d == S_HIGH) && (state_q != S_HIGH) && (state_q != S_CHK_LOW)) begin
      level_d = 1'b1;
      rise_d  = 1'b1;
    end
    if ((state_d == S_LOW) && (state_q != S_LOW) && (state_q != S_CHK_HIGH)) begin
      level_d = 1'b0;
      fall_d  = 1'b1;
    end
    if (((state_q == S_CHK_HIGH) && (state_d == S_LOW)) ||
        ((state_q == S_CHK_LOW) && (state_d == S_HIGH))) begin
      glitch_inc = 1'b1;
    end
  end

  always_ff @(posedge clk_dst) begin
    if (rst) begin
      level_out  <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      level_out  <= level_d;
      rise_pulse <= rise_d;
      fall_pulse <= fall_d;
    end
  end

  assign busy = (state_q == S_CHK_HIGH) || (state_q == S_CHK_LOW);

  sat_counter #(
    .WIDTH(GLITCH_CNT_W)
  ) u_glitch_cnt (
    .clk  (clk_dst),
    .rst  (rst),
    .inc  (glitch_inc),
    .clr  (glitch_clr),
    .count(glitch_count)
  );

endmodule

// File: tb/tb_sync_debounce_edge.sv
// Directed bench for sync_debounce_edge: three instances cover the default
// configuration, a 2-bit glitch counter, and STABLE_CYCLES=1.
module tb_sync_debounce_edge;

  logic       clk_dst;
  logic       rst;

  logic       sigA, clrA, levelA, riseA, fallA, busyA;
  logic [7:0] cntA;
  logic       sigB, clrB, levelB, riseB, fallB, busyB;
  logic [1:0] cntB;
  logic       sigC, clrC, levelC, riseC, fallC, busyC;
  logic [7:0] cntC;

  int checks   = 0;
  int failures = 0;

  sync_debounce_edge #(.STABLE_CYCLES(4), .GLITCH_CNT_W(8)) dutA (
    .clk_dst(clk_dst), .rst(rst), .signal_sync(sigA), .glitch_clr(clrA),
    .level_out(levelA), .rise_pulse(riseA), .fall_pulse(fallA),
    .busy(busyA), .glitch_count(cntA)
  );

  sync_debounce_edge #(.STABLE_CYCLES(4), .GLITCH_CNT_W(2)) dutB (
    .clk_dst(clk_dst), .rst(rst), .signal_sync(sigB), .glitch_clr(clrB),
    .level_out(levelB), .rise_pulse(riseB), .fall_pulse(fallB),
    .busy(busyB), .glitch_count(cntB)
  );

  sync_debounce_edge #(.STABLE_CYCLES(1), .GLITCH_CNT_W(8)) dutC (
    .clk_dst(clk_dst), .rst(rst), .signal_sync(sigC), .glitch_clr(clrC),
    .level_out(levelC), .rise_pulse(riseC), .fall_pulse(fallC),
    .busy(busyC), .glitch_count(cntC)
  );

  initial clk_dst = 1'b0;
  always #5 clk_dst = ~clk_dst;

  task automatic tick();
    @(posedge clk_dst);
    #1;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    sigA = 1'b1;
    repeat (3) tick();
    checks++; if (levelA !== 1'b0) begin failures++; $display("FAIL reset_level: got %0b expected 0", levelA); end
    checks++; if (riseA !== 1'b0) begin failures++; $display("FAIL reset_rise: got %0b expected 0", riseA); end
    checks++; if (fallA !== 1'b0) begin failures++; $display("FAIL reset_fall: got %0b expected 0", fallA); end
    checks++; if (busyA !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b expected 0", busyA); end
    checks++; if (cntA !== 8'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", cntA); end
    rst  = 1'b0;
    sigA = 1'b0;
    tick();
    checks++; if (busyA !== 1'b0) begin failures++; $display("FAIL reset_idle_busy: got %0b expected 0", busyA); end
    sigA = 1'b1;
    tick();
    checks++; if (busyA !== 1'b1) begin failures++; $display("FAIL reset_start_qual: got busy %0b expected 1", busyA); end
    rst = 1'b1;
    tick();
    checks++; if (busyA !== 1'b0) begin failures++; $display("FAIL reset_priority: got busy %0b expected 0", busyA); end
    rst  = 1'b0;
    sigA = 1'b0;
    tick();
  endtask

  task automatic test_clean_edges();
    sigA = 1'b1;
    repeat (3) tick();
    checks++; if (levelA !== 1'b0 || riseA !== 1'b0) begin failures++; $display("FAIL rise_early: got level %0b rise %0b expected 0 0", levelA, riseA); end
    checks++; if (busyA !== 1'b1) begin failures++; $display("FAIL rise_busy: got %0b expected 1", busyA); end
    tick();
    checks++; if (levelA !== 1'b1 || riseA !== 1'b1) begin failures++; $display("FAIL rise_accept: got level %0b rise %0b expected 1 1", levelA, riseA); end
    checks++; if (busyA !== 1'b0 || fallA !== 1'b0) begin failures++; $display("FAIL rise_accept_side: got busy %0b fall %0b expected 0 0", busyA, fallA); end
    tick();
    checks++; if (riseA !== 1'b0 || levelA !== 1'b1) begin failures++; $display("FAIL rise_width: got rise %0b level %0b expected 0 1", riseA, levelA); end
    sigA = 1'b0;
    repeat (3) tick();
    checks++; if (fallA !== 1'b0 || levelA !== 1'b1) begin failures++; $display("FAIL fall_early: got fall %0b level %0b expected 0 1", fallA, levelA); end
    tick();
    checks++; if (fallA !== 1'b1 || levelA !== 1'b0 || riseA !== 1'b0) begin failures++; $display("FAIL fall_accept: got fall %0b level %0b rise %0b expected 1 0 0", fallA, levelA, riseA); end
    tick();
    checks++; if (fallA !== 1'b0) begin failures++; $display("FAIL fall_width: got %0b expected 0", fallA); end
  endtask

  task automatic test_glitch();
    logic [4:0] pattern;
    int busyCnt;
    int edgeCnt;
    int levelCnt;
    pattern  = 5'b00011;
    busyCnt  = 0;
    edgeCnt  = 0;
    levelCnt = 0;
    for (int i = 0; i < 5; i++) begin
      sigA = pattern[i];
      tick();
      if (busyA === 1'b1) busyCnt++;
      if (riseA === 1'b1 || fallA === 1'b1) edgeCnt++;
      if (levelA === 1'b1) levelCnt++;
    end
    checks++; if (busyCnt != 2) begin failures++; $display("FAIL glitch_busy_cycles: got %0d expected 2", busyCnt); end
    checks++; if (edgeCnt != 0) begin failures++; $display("FAIL glitch_pulse: got %0d expected 0", edgeCnt); end
    checks++; if (levelCnt != 0) begin failures++; $display("FAIL glitch_level: got %0d expected 0", levelCnt); end
    checks++; if (cntA !== 8'd1) begin failures++; $display("FAIL glitch_count: got %0d expected 1", cntA); end
  endtask

  task automatic test_reset_mid_qual();
    clrA = 1'b1;
    tick();
    clrA = 1'b0;
    sigA = 1'b1;
    repeat (3) tick();
    checks++; if (busyA !== 1'b1) begin failures++; $display("FAIL midq_busy: got %0b expected 1", busyA); end
    rst = 1'b1;
    tick();
    checks++; if (riseA !== 1'b0 || levelA !== 1'b0 || busyA !== 1'b0) begin failures++; $display("FAIL midq_abandon: got rise %0b level %0b busy %0b expected 0 0 0", riseA, levelA, busyA); end
    checks++; if (cntA !== 8'd0) begin failures++; $display("FAIL midq_count: got %0d expected 0", cntA); end
    rst = 1'b0;
    repeat (3) tick();
    checks++; if (riseA !== 1'b0 || busyA !== 1'b1) begin failures++; $display("FAIL midq_restart: got rise %0b busy %0b expected 0 1", riseA, busyA); end
    tick();
    checks++; if (riseA !== 1'b1 || levelA !== 1'b1) begin failures++; $display("FAIL midq_accept: got rise %0b level %0b expected 1 1", riseA, levelA); end
    sigA = 1'b0;
    repeat (4) tick();
    checks++; if (levelA !== 1'b0 || cntA !== 8'd0) begin failures++; $display("FAIL midq_final: got level %0b count %0d expected 0 0", levelA, cntA); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      sigB = 1'b1;
      tick();
      sigB = 1'b0;
      tick();
      if (i == 1) begin
        checks++; if (cntB !== 2'd2) begin failures++; $display("FAIL sat_two: got %0d expected 2", cntB); end
      end
    end
    checks++; if (cntB !== 2'd3) begin failures++; $display("FAIL sat_hold: got %0d expected 3", cntB); end
    checks++; if (levelB !== 1'b0) begin failures++; $display("FAIL sat_level: got %0b expected 0", levelB); end
    sigB = 1'b1;
    tick();
    sigB = 1'b0;
    clrB = 1'b1;
    tick();
    clrB = 1'b0;
    checks++; if (cntB !== 2'd0) begin failures++; $display("FAIL sat_clear_wins: got %0d expected 0", cntB); end
    sigB = 1'b1;
    tick();
    sigB = 1'b0;
    tick();
    checks++; if (cntB !== 2'd1) begin failures++; $display("FAIL sat_after_clear: got %0d expected 1", cntB); end
  endtask

  task automatic test_stable_one();
    sigC = 1'b1;
    tick();
    checks++; if (riseC !== 1'b1 || levelC !== 1'b1) begin failures++; $display("FAIL one_rise: got rise %0b level %0b expected 1 1", riseC, levelC); end
    checks++; if (busyC !== 1'b0) begin failures++; $display("FAIL one_busy_rise: got %0b expected 0", busyC); end
    sigC = 1'b0;
    tick();
    checks++; if (fallC !== 1'b1 || levelC !== 1'b0 || riseC !== 1'b0) begin failures++; $display("FAIL one_fall: got fall %0b level %0b rise %0b expected 1 0 0", fallC, levelC, riseC); end
    checks++; if (busyC !== 1'b0) begin failures++; $display("FAIL one_busy_fall: got %0b expected 0", busyC); end
    tick();
    checks++; if (fallC !== 1'b0 || cntC !== 8'd0) begin failures++; $display("FAIL one_settle: got fall %0b count %0d expected 0 0", fallC, cntC); end
  endtask

  initial begin
    rst  = 1'b1;
    sigA = 1'b0; clrA = 1'b0;
    sigB = 1'b0; clrB = 1'b0;
    sigC = 1'b0; clrC = 1'b0;
    test_reset();
    test_clean_edges();
    test_glitch();
    test_reset_mid_qual();
    test_saturation();
    test_stable_one();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_debounce_edge.md
# sync_debounce_edge

Conditions a single-bit level that has already crossed into the `clk_dst` domain through the two-flop synchroniser, and sits directly downstream of it. The block rejects glitches shorter than a programmable stability window and emits a clean debounced level with one-cycle rise and fall pulses. It also keeps a saturating count of rejected glitches for status readout.

## Interface
- `STABLE_CYCLES`, default 4: consecutive identical samples required to accept a level change. Legal range is ≥1.
- `GLITCH_CNT_W`, default 8: width of the glitch counter. Legal range is ≥1.

Clock and reset are fixed: one clock, `clk_dst`, and a synchronous, active-high reset, `rst`.

- `clk_dst`  in  1  destination-domain clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset; has priority over every other input.
- `signal_sync`  in  1  level from the synchroniser output; already metastability-filtered.
- `glitch_clr`  in  1  synchronous clear of `glitch_count`.
- `level_out`  out  1  debounced level; registered.
- `rise_pulse`  out  1  one-cycle pulse on an accepted 0→1 change; registered.
- `fall_pulse`  out  1  one-cycle pulse on an accepted 1→0 change; registered.
- `busy`  out  1  high while a candidate change is being qualified; decoded from the state register.
- `glitch_count`  out  GLITCH_CNT_W  number of rejected candidate changes; saturating.

## Operation
- **States:** `S_LOW`, `S_CHK_HIGH`, `S_HIGH`, `S_CHK_LOW`.
- **Qualify counter:** `qcnt`, width `$clog2(STABLE_CYCLES+1)`.
- **S_LOW:**
  - `signal_sync`=1 → `S_CHK_HIGH`, `qcnt`=1.
  - If `STABLE_CYCLES`=1, go straight to `S_HIGH` with the acceptance actions below.
- **S_CHK_HIGH:**
  - `signal_sync`=1 → `qcnt`+1.
  - When `qcnt`+1 == `STABLE_CYCLES`: → `S_HIGH`, `level_out`←1, `rise_pulse`←1.
  - `signal_sync`=0 → `S_LOW`, `qcnt`←0, glitch counter increments.
- **S_HIGH / S_CHK_LOW:** mirror of the above with polarity inverted; acceptance sets `level_out`←0 and `fall_pulse`←1.
- **Pulses:** `rise_pulse` and `fall_pulse` default to 0 every cycle and are never high together.
- **busy:** 1 exactly in `S_CHK_HIGH` and `S_CHK_LOW`.
- **Glitch counter:**
  - Saturates at all-ones.
  - `glitch_clr` and a glitch in the same cycle → result 0 (clear wins).
  - A glitch while saturated leaves the value unchanged.
- **Reset values:** state `S_LOW`, `qcnt`=0, `level_out`=0, `rise_pulse`=0, `fall_pulse`=0, `glitch_count`=0, `busy`=0.
- **Reset mid-qualification:** the candidate is abandoned, no pulse is emitted and no glitch is counted.

## Timing
- **Acceptance latency:** with `signal_sync` sampled 1 at edges k … k+STABLE_CYCLES−1, `level_out` and `rise_pulse` go high after edge k+STABLE_CYCLES−1.
- **Pulse width:** `rise_pulse` returns to 0 after the following edge.
- **Total latency from source:** 2 synchroniser cycles + `STABLE_CYCLES` cycles.
- **Back-to-back changes:** the minimum accepted pulse width on the input is `STABLE_CYCLES` cycles. A change that is accepted and then reversed starts a fresh qualification on the next cycle.
- **No combinational paths:** nothing runs from inputs to outputs; `busy` is decoded from registered state only.

## Structure
- **Shared package `sync_pkg`:** holds the state enum `dbnc_state_t` and the helper constant for the `qcnt` width.
- **Sub-module `sat_counter`:**
  - Parameter: width.
  - Inputs: `inc`, `clr`.
  - Clear has priority over increment.
  - Reusable by other status blocks in the CDC path.
- **Top-level contents:** the FSM, `qcnt`, and the output registers.

## Test plan
- **Reset:** assert `rst` for 3 cycles with `signal_sync`=1 → all outputs 0, `busy`=0. After deassertion, qualification starts from `S_LOW`.
- **Clean rise, `STABLE_CYCLES`=4:** `signal_sync`=1 sampled at edges 10–13 → `level_out`=1 and `rise_pulse`=1 after edge 13, `rise_pulse`=0 after edge 14. Then 0 sampled at edges 20–23 → `fall_pulse` high only after edge 23.
- **Glitch:** `signal_sync` high for 2 cycles then low → `level_out` stays 0, no pulse, `glitch_count`=1, `busy` high for exactly 2 cycles.
- **Saturation and clear, `GLITCH_CNT_W`=2:**
  - 5 glitches → `glitch_count`=3.
  - `glitch_clr` coincident with a 6th glitch → 0.
  - 7th glitch → 1.
- **Reset mid-qualification:** `rst` asserted at `qcnt`=3 of 4 → no `rise_pulse`, `glitch_count` unchanged at 0, state `S_LOW`.
- **`STABLE_CYCLES`=1:** single-cycle high input → `rise_pulse` after the same edge. On the next cycle the low input causes `fall_pulse`. `busy` is never asserted.
